cache_block: RTL and testbench
==============================

CACHE_BLOCK -- requirements
Module: cache_block

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of key/value entries (power of two, >=2).
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key width in bits.
REQ-003 SHALL have parameter VALUE_WIDTH, default 64, value width in bits.
REQ-004 SHALL have parameter EVICT_ON_FULL, default 1; 1 = PUT miss on full replaces an entry, 0 = PUT miss on full is rejected.
REQ-005 SHALL have port clk input 1: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid input 1: request present.
REQ-008 SHALL have port req_ready output 1: block can accept a request.
REQ-009 SHALL have port req_op input 2: operation code; 00 GET, 01 PUT, 10 DEL, 11 CLEAR.
REQ-010 SHALL have port req_key input KEY_WIDTH: lookup key.
REQ-011 SHALL have port req_value input VALUE_WIDTH: PUT data.
REQ-012 SHALL have port resp_valid output 1: response present.
REQ-013 SHALL have port resp_ready input 1: consumer accepts the response.
REQ-014 SHALL have port resp_hit output 1: key matched a valid entry.
REQ-015 SHALL have port resp_value output VALUE_WIDTH: data returned by the operation.
REQ-016 SHALL have port resp_evicted output 1: PUT displaced another key.
REQ-017 SHALL have port resp_err output 1: PUT rejected.
REQ-018 SHALL have port count output $clog2(NUM_ENTRIES+1): number of valid entries.
REQ-019 SHALL have port full output 1: high when count == NUM_ENTRIES.

Function
REQ-020 SHALL implement a two-state FSM: IDLE (req_ready=1, resp_valid=0) and RESP (req_ready=0, resp_valid=1).
REQ-021 In IDLE, req_valid=1 SHALL accept the request, execute it on that edge, register all resp_* outputs, and enter RESP, giving resp_valid exactly 1 cycle after acceptance.
REQ-022 In RESP, resp_* SHALL be held stable until resp_valid && resp_ready, then the FSM SHALL return to IDLE, giving a maximum rate of one operation per 2 cycles.
REQ-023 Lookup SHALL compare req_key against every valid entry in parallel; by construction at most one entry matches.
REQ-024 GET hit SHALL return resp_hit=1 and resp_value=stored value; GET miss SHALL return resp_hit=0 and resp_value=0; GET SHALL leave state unchanged.
REQ-025 PUT hit SHALL overwrite the matching entry's value, return resp_hit=1 and resp_value=old value, and leave count unchanged.
REQ-026 PUT miss while not full SHALL write the lowest-index invalid entry, set its valid bit, increment count, and return resp_hit=0 and resp_value=0.
REQ-027 PUT miss while full with EVICT_ON_FULL=1 SHALL:
- overwrite the entry at victim pointer vptr;
- return resp_evicted=1 and resp_value=displaced value;
- advance vptr by 1, wrapping from NUM_ENTRIES-1 to 0;
- leave count unchanged.
REQ-028 PUT miss while full with EVICT_ON_FULL=0 SHALL leave state unchanged and return resp_err=1 and resp_value=0.
REQ-029 DEL hit SHALL clear the entry's valid bit, decrement count, and return resp_hit=1 and resp_value=deleted value; DEL miss SHALL leave state unchanged and return resp_hit=0.
REQ-030 CLEAR SHALL clear all valid bits, set count=0 and vptr=0, and return all resp_* flags=0 and resp_value=0.
REQ-031 Flags not named for an operation SHALL be 0 in its response.
REQ-032 vptr SHALL be $clog2(NUM_ENTRIES) bits wide and change only on eviction, CLEAR or reset.
REQ-033 req_* inputs SHALL be ignored while in RESP.
REQ-034 count and full SHALL reflect state after the executed operation, updated on the acceptance edge.

Reset
REQ-035 rst=1 SHALL immediately force:
- FSM=IDLE;
- all valid bits=0, count=0, full=0, vptr=0;
- resp_valid=0, resp_hit=0, resp_evicted=0, resp_err=0, resp_value=0.
REQ-036 Key/value storage SHALL need no reset; it SHALL never be visible while its valid bit is 0.
REQ-037 rst asserted while in RESP SHALL drop the pending response without handshake.

Verification
REQ-038 Reset, then PUT key 0x0001 value 0xA5 -> resp 1 cycle later with hit=0, count=1; GET 0x0001 -> hit=1, value=0xA5.
REQ-039 PUT 0x0001 value 0xB6 over an existing key -> hit=1, value=0xA5, count stays 1; GET -> 0xB6.
REQ-040 Fill 16 distinct keys, then PUT a new key (EVICT_ON_FULL=1) -> evicted=1, entry 0's value returned, full stays 1; repeat 16 times -> vptr wraps to 0.
REQ-041 Full with EVICT_ON_FULL=0, PUT new key -> err=1, count=16, contents unchanged.
REQ-042 DEL an existing key -> hit=1, count-1; DEL again -> hit=0; next PUT fills the freed lowest index.
REQ-043 Hold resp_ready=0 for 5 cycles -> resp stable and req_ready=0; assert rst mid-RESP -> resp_valid=0 at once; CLEAR -> count=0.

Source files
------------

// File: rtl/cache_block.sv
`default_nettype none
// ============================================================================
// Module      : cache_block
// Description : Fully associative key/value store with GET, PUT, DEL and
//               CLEAR operations. Each accepted request is executed on its
//               acceptance edge. The response is registered and held until
//               it is handshaked.
//               A PUT that misses while the store is full either replaces
//               the entry at a round-robin victim pointer or is rejected,
//               selected by EVICT_ON_FULL.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready/req_op/req_key/req_value : request side
//               resp_valid/resp_ready/resp_hit/resp_value/
//               resp_evicted/resp_err                        : response side
//               count, full                                  : occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module cache_block #(
    parameter int NUM_ENTRIES   = 16,
    parameter int KEY_WIDTH     = 16,
    parameter int VALUE_WIDTH   = 64,
    parameter int EVICT_ON_FULL = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [1:0]                         req_op,
    input  logic [KEY_WIDTH-1:0]               req_key,
    input  logic [VALUE_WIDTH-1:0]             req_value,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic                               resp_hit,
    output logic [VALUE_WIDTH-1:0]             resp_value,
    output logic                               resp_evicted,
    output logic                               resp_err,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count,
    output logic                               full
);

    localparam int         c_IDX_W  = $clog2(NUM_ENTRIES);
    localparam int         c_CNT_W  = $clog2(NUM_ENTRIES+1);
    localparam logic [1:0] c_OP_GET = 2'b00;
    localparam logic [1:0] c_OP_PUT = 2'b01;
    localparam logic [1:0] c_OP_DEL = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [NUM_ENTRIES-1:0]   r_valid;
    logic [NUM_ENTRIES-1:0]   w_valid_next;
    logic [KEY_WIDTH-1:0]     r_key  [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0]   r_data [NUM_ENTRIES];
    logic [c_CNT_W-1:0]       r_count;
    logic [c_CNT_W-1:0]       w_count_next;
    logic [c_IDX_W-1:0]       r_vptr;
    logic [c_IDX_W-1:0]       w_vptr_next;

    logic                     r_hit, r_evicted, r_err;
    logic [VALUE_WIDTH-1:0]   r_value;
    logic                     w_hit_next, w_evicted_next, w_err_next;
    logic [VALUE_WIDTH-1:0]   w_value_next;

    logic [NUM_ENTRIES-1:0]   w_match;
    logic                     w_any_hit;
    logic [c_IDX_W-1:0]       w_hit_idx;
    logic [c_IDX_W-1:0]       w_free_idx;
    logic                     w_full;
    logic                     w_accept;
    logic                     w_wr_en;
    logic [c_IDX_W-1:0]       w_wr_idx;

    // Parallel key compare; a key is only ever stored once, so at most one
    // bit of w_match is set.
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_match
        assign w_match[g] = r_valid[g] && (r_key[g] == req_key);
    end

    assign w_any_hit = |w_match;
    assign w_full    = (r_count == c_CNT_W'(NUM_ENTRIES));

    // Descending scan so the lowest index wins for the free-slot search.
    always_comb begin
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_idx = c_IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_valid_next   = r_valid;
        w_count_next   = r_count;
        w_vptr_next    = r_vptr;
        w_accept       = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_idx       = w_free_idx;
        w_hit_next     = 1'b0;
        w_evicted_next = 1'b0;
        w_err_next     = 1'b0;
        w_value_next   = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RESP;
                    case (req_op)
                        c_OP_GET: begin
                            if (w_any_hit) begin
                                w_hit_next   = 1'b1;
                                w_value_next = r_data[w_hit_idx];
                            end
                        end
                        c_OP_PUT: begin
                            if (w_any_hit) begin
                                w_wr_en      = 1'b1;
                                w_wr_idx     = w_hit_idx;
                                w_hit_next   = 1'b1;
                                w_value_next = r_data[w_hit_idx];
                            end else if (!w_full) begin
                                w_wr_en                  = 1'b1;
                                w_wr_idx                 = w_free_idx;
                                w_valid_next[w_free_idx] = 1'b1;
                                w_count_next             = r_count + c_CNT_W'(1);
                            end else if (EVICT_ON_FULL != 0) begin
                                // Power-of-two depth: the increment wraps
                                // naturally from the last index to 0.
                                w_wr_en        = 1'b1;
                                w_wr_idx       = r_vptr;
                                w_evicted_next = 1'b1;
                                w_value_next   = r_data[r_vptr];
                                w_vptr_next    = r_vptr + c_IDX_W'(1);
                            end else begin
                                w_err_next = 1'b1;
                            end
                        end
                        c_OP_DEL: begin
                            if (w_any_hit) begin
                                w_valid_next[w_hit_idx] = 1'b0;
                                w_count_next            = r_count - c_CNT_W'(1);
                                w_hit_next              = 1'b1;
                                w_value_next            = r_data[w_hit_idx];
                            end
                        end
                        default: begin
                            w_valid_next = '0;
                            w_count_next = '0;
                            w_vptr_next  = '0;
                        end
                    endcase
                end
            end
            default: begin
                if (resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_valid   <= '0;
            r_count   <= '0;
            r_vptr    <= '0;
            r_hit     <= 1'b0;
            r_evicted <= 1'b0;
            r_err     <= 1'b0;
            r_value   <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            r_vptr  <= w_vptr_next;
            if (w_accept) begin
                r_hit     <= w_hit_next;
                r_evicted <= w_evicted_next;
                r_err     <= w_err_next;
                r_value   <= w_value_next;
            end
        end
    end

    // Key/value storage is gated by r_valid everywhere it is read, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_key[w_wr_idx]  <= req_key;
            r_data[w_wr_idx] <= req_value;
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_hit     = r_hit;
    assign resp_value   = r_value;
    assign resp_evicted = r_evicted;
    assign resp_err     = r_err;
    assign count        = r_count;
    assign full         = w_full;

endmodule
`default_nettype wire

// File: tb/tb_cache_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_block
// Description : Self-checking bench for cache_block. Two instances share the
//               request stream: one replaces on a full PUT miss, the other
//               rejects. Each is compared against its own array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_block;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        resp_ready;
    logic [1:0]  req_op;
    logic [15:0] req_key;
    logic [63:0] req_value;

    logic        d0_req_ready, d0_resp_valid, d0_hit, d0_ev, d0_err, d0_full;
    logic [63:0] d0_value;
    logic [4:0]  d0_count;
    logic        d1_req_ready, d1_resp_valid, d1_hit, d1_ev, d1_err, d1_full;
    logic [63:0] d1_value;
    logic [4:0]  d1_count;

    int total;
    int bad;

    // Model state, index 0 = evicting instance, 1 = rejecting instance.
    logic        m_v [2][16];
    logic [15:0] m_k [2][16];
    logic [63:0] m_d [2][16];
    int          m_vp [2];
    logic        e_hit [2];
    logic        e_ev  [2];
    logic        e_err [2];
    logic [63:0] e_val [2];

    cache_block #(.NUM_ENTRIES(16), .KEY_WIDTH(16), .VALUE_WIDTH(64), .EVICT_ON_FULL(1)) u_dut_evict (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d0_req_ready),
        .req_op(req_op), .req_key(req_key), .req_value(req_value),
        .resp_valid(d0_resp_valid), .resp_ready(resp_ready), .resp_hit(d0_hit),
        .resp_value(d0_value), .resp_evicted(d0_ev), .resp_err(d0_err),
        .count(d0_count), .full(d0_full)
    );

    cache_block #(.NUM_ENTRIES(16), .KEY_WIDTH(16), .VALUE_WIDTH(64), .EVICT_ON_FULL(0)) u_dut_reject (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d1_req_ready),
        .req_op(req_op), .req_key(req_key), .req_value(req_value),
        .resp_valid(d1_resp_valid), .resp_ready(resp_ready), .resp_hit(d1_hit),
        .resp_value(d1_value), .resp_evicted(d1_ev), .resp_err(d1_err),
        .count(d1_count), .full(d1_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count(input int d);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (m_v[d][i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m_v[d][i] = 1'b0;
            m_vp[d]  = 0;
            e_hit[d] = 1'b0;
            e_ev[d]  = 1'b0;
            e_err[d] = 1'b0;
            e_val[d] = '0;
        end
    endtask

    task automatic model_op(input int d, input logic [1:0] op, input logic [15:0] key, input logic [63:0] val);
        int hi;
        int fi;
        hi = -1;
        fi = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_v[d][i] && m_k[d][i] == key && hi < 0) hi = i;
            if (!m_v[d][i] && fi < 0) fi = i;
        end
        e_hit[d] = 1'b0;
        e_ev[d]  = 1'b0;
        e_err[d] = 1'b0;
        e_val[d] = '0;
        case (op)
            2'd0: if (hi >= 0) begin
                e_hit[d] = 1'b1;
                e_val[d] = m_d[d][hi];
            end
            2'd1: begin
                if (hi >= 0) begin
                    e_hit[d]     = 1'b1;
                    e_val[d]     = m_d[d][hi];
                    m_d[d][hi]   = val;
                end else if (fi >= 0) begin
                    m_v[d][fi] = 1'b1;
                    m_k[d][fi] = key;
                    m_d[d][fi] = val;
                end else if (d == 0) begin
                    e_ev[d]          = 1'b1;
                    e_val[d]         = m_d[d][m_vp[d]];
                    m_k[d][m_vp[d]]  = key;
                    m_d[d][m_vp[d]]  = val;
                    m_vp[d]          = (m_vp[d] + 1) % 16;
                end else begin
                    e_err[d] = 1'b1;
                end
            end
            2'd2: if (hi >= 0) begin
                e_hit[d]   = 1'b1;
                e_val[d]   = m_d[d][hi];
                m_v[d][hi] = 1'b0;
            end
            default: begin
                for (int i = 0; i < 16; i++) m_v[d][i] = 1'b0;
                m_vp[d] = 0;
            end
        endcase
    endtask

    task automatic check_resp();
        chk("d0_resp_valid", d0_resp_valid, 1'b1);
        chk("d0_req_ready",  d0_req_ready,  1'b0);
        chk("d0_hit",        d0_hit,        e_hit[0]);
        chk("d0_value",      d0_value,      e_val[0]);
        chk("d0_evicted",    d0_ev,         e_ev[0]);
        chk("d0_err",        d0_err,        e_err[0]);
        chk("d0_count",      d0_count,      model_count(0));
        chk("d0_full",       d0_full,       model_count(0) == 16);
        chk("d1_resp_valid", d1_resp_valid, 1'b1);
        chk("d1_req_ready",  d1_req_ready,  1'b0);
        chk("d1_hit",        d1_hit,        e_hit[1]);
        chk("d1_value",      d1_value,      e_val[1]);
        chk("d1_evicted",    d1_ev,         e_ev[1]);
        chk("d1_err",        d1_err,        e_err[1]);
        chk("d1_count",      d1_count,      model_count(1));
        chk("d1_full",       d1_full,       model_count(1) == 16);
    endtask

    task automatic check_idle_reset();
        chk("rst_d0_resp_valid", d0_resp_valid, 1'b0);
        chk("rst_d0_req_ready",  d0_req_ready,  1'b1);
        chk("rst_d0_hit",        d0_hit,        1'b0);
        chk("rst_d0_value",      d0_value,      64'd0);
        chk("rst_d0_evicted",    d0_ev,         1'b0);
        chk("rst_d0_err",        d0_err,        1'b0);
        chk("rst_d0_count",      d0_count,      5'd0);
        chk("rst_d0_full",       d0_full,       1'b0);
        chk("rst_d1_resp_valid", d1_resp_valid, 1'b0);
        chk("rst_d1_req_ready",  d1_req_ready,  1'b1);
        chk("rst_d1_count",      d1_count,      5'd0);
        chk("rst_d1_value",      d1_value,      64'd0);
    endtask

    // Called at #1 after a rising edge with both instances idle.
    task automatic do_op(input logic [1:0] op, input logic [15:0] key, input logic [63:0] val, input int hold);
        req_valid  = 1'b1;
        req_op     = op;
        req_key    = key;
        req_value  = val;
        resp_ready = 1'b0;
        model_op(0, op, key, val);
        model_op(1, op, key, val);
        @(posedge clk); #1;
        check_resp();
        // Requests presented while a response is pending must be ignored.
        req_op    = 2'($urandom_range(0, 3));
        req_key   = 16'($urandom_range(0, 23));
        req_value = {$urandom, $urandom};
        repeat (hold) begin
            @(posedge clk); #1;
            check_resp();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("d0_resp_drop", d0_resp_valid, 1'b0);
        chk("d0_ready_back", d0_req_ready, 1'b1);
        chk("d1_resp_drop", d1_resp_valid, 1'b0);
        resp_ready = 1'b0;
    endtask

    initial begin
        int r;
        logic [1:0] op;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_op     = 2'd0;
        req_key    = '0;
        req_value  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_reset();
        rst = 1'b0;
        @(posedge clk); #1;

        // First insert and read back.
        do_op(2'd1, 16'h0001, 64'hA5, 0);
        do_op(2'd0, 16'h0001, 64'h0, 0);
        // Overwrite an existing key while stalling the response.
        do_op(2'd1, 16'h0001, 64'hB6, 5);
        do_op(2'd0, 16'h0001, 64'h0, 0);

        // Fill to capacity, then push 17 new keys to wrap the victim pointer.
        for (int i = 1; i < 16; i++) do_op(2'd1, 16'h0100 + 16'(i), 64'h1000 + 64'(i), 0);
        for (int i = 0; i < 17; i++) do_op(2'd1, 16'h0200 + 16'(i), 64'h2000 + 64'(i), 1);
        do_op(2'd0, 16'h0105, 64'h0, 0);

        // Delete, delete again, refill the freed slot.
        do_op(2'd2, 16'h0107, 64'h0, 0);
        do_op(2'd2, 16'h0107, 64'h0, 0);
        do_op(2'd2, 16'h0203, 64'h0, 0);
        do_op(2'd2, 16'h0203, 64'h0, 0);
        do_op(2'd1, 16'h0300, 64'h3000, 0);
        do_op(2'd0, 16'h0300, 64'h0, 0);

        do_op(2'd3, 16'h0000, 64'h0, 2);
        do_op(2'd0, 16'h0300, 64'h0, 0);

        // Randomised traffic over a small key space so hits, evictions and
        // rejects all occur.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 39));
            if (r < 12)       op = 2'd0;
            else if (r < 32)  op = 2'd1;
            else if (r < 39)  op = 2'd2;
            else              op = 2'd3;
            do_op(op, 16'($urandom_range(0, 23)), {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        // Reset while a response is pending drops it immediately.
        do_op(2'd1, 16'h0042, 64'h42, 0);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_key   = 16'h0042;
        @(posedge clk); #1;
        chk("pre_rst_resp_valid", d0_resp_valid, 1'b1);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_idle_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(2'd0, 16'h0042, 64'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
